// File: rtl/sram_bank_array.sv
// ---------------------------------------------------------------------------
// sram_bank_array
//
// Responder end of the memory controller's per-SRAM control bus. Holds every
// SRAM bank used by the dot-product engine: the operand banks (indices
// 0..Nums_SRAM_In-1) followed by the result banks. Each bank is an
// independent dual-port (one read, one write) memory with registered read
// data, a self-timed clear sequence and a sticky access-error flag.
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   Bank_reset_n   asynchronous active-low reset (memory contents untouched)
//   Mem_Clear      per-bank clear request, rising-edge detected
//   En_Chip_Select per-bank select; no access or error without it
//   En_Read        per-bank read enable
//   En_Write       per-bank write enable
//   Addr_Read      packed read addresses,  bank i at [i*Addr_Width +: Addr_Width]
//   Addr_Write     packed write addresses, bank i at [i*Addr_Width +: Addr_Width]
//   Data_In        packed write data,      bank i at [i*Data_Width +: Data_Width]
//   Err_Clear      synchronous clear of all Access_Err bits
//   Data_Out       packed registered read data (one cycle after the request)
//   Data_Valid     per-bank, high only in the cycle Data_Out holds a fresh read
//   Clear_Busy     per-bank, bank is running its clear sequence
//   Access_Err     per-bank sticky error flag
// ---------------------------------------------------------------------------
module sram_bank_array #(
    parameter int Addr_Width    = 4,
    parameter int Ram_Depth     = 1 << Addr_Width,
    parameter int Nums_SRAM_In  = 2,
    parameter int Nums_SRAM_Out = 1,
    parameter int Nums_SRAM     = Nums_SRAM_In + Nums_SRAM_Out,
    parameter int Data_Width    = 8
) (
    input  logic                            clk,
    input  logic                            Bank_reset_n,
    input  logic [Nums_SRAM-1:0]            Mem_Clear,
    input  logic [Nums_SRAM-1:0]            En_Chip_Select,
    input  logic [Nums_SRAM-1:0]            En_Read,
    input  logic [Nums_SRAM-1:0]            En_Write,
    input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Read,
    input  logic [Nums_SRAM*Addr_Width-1:0] Addr_Write,
    input  logic [Nums_SRAM*Data_Width-1:0] Data_In,
    input  logic                            Err_Clear,
    output logic [Nums_SRAM*Data_Width-1:0] Data_Out,
    output logic [Nums_SRAM-1:0]            Data_Valid,
    output logic [Nums_SRAM-1:0]            Clear_Busy,
    output logic [Nums_SRAM-1:0]            Access_Err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bank_state_e;

    // One extra bit so that a depth of exactly 2^Addr_Width is representable.
    localparam logic [Addr_Width:0]   DEPTH     = (Addr_Width + 1)'(Ram_Depth);
    localparam logic [Addr_Width-1:0] LAST_ADDR = Addr_Width'(Ram_Depth - 1);

    // Previous-cycle Mem_Clear, shared by all banks for edge detection.
    logic [Nums_SRAM-1:0] mem_clear_q;

    always_ff @(posedge clk or negedge Bank_reset_n) begin
        if (!Bank_reset_n) begin
            mem_clear_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            mem_clear_q <= Mem_Clear;
        end
    end

    for (genvar i = 0; i < Nums_SRAM; i++) begin : g_bank

        bank_state_e             state_q, state_d;
        logic [Addr_Width-1:0]   ptr_q, ptr_d;
        logic [Data_Width-1:0]   mem [Ram_Depth];
        logic [Data_Width-1:0]   rdata_q;
        logic                    valid_q;
        logic                    err_q;

        logic [Addr_Width-1:0]   raddr;
        logic [Addr_Width-1:0]   waddr;
        logic [Data_Width-1:0]   wdata;
        logic                    sel_rd;
        logic                    sel_wr;
        logic                    rd_ok;
        logic                    wr_ok;
        logic                    busy;
        logic                    clr_rise;
        logic                    err_set;
        logic                    do_read;

        assign raddr    = Addr_Read[i*Addr_Width +: Addr_Width];
        assign waddr    = Addr_Write[i*Addr_Width +: Addr_Width];
        assign wdata    = Data_In[i*Data_Width +: Data_Width];
        assign sel_rd   = En_Chip_Select[i] & En_Read[i];
        assign sel_wr   = En_Chip_Select[i] & En_Write[i];
        assign rd_ok    = {1'b0, raddr} < DEPTH;
        assign wr_ok    = {1'b0, waddr} < DEPTH;
        assign busy     = (state_q == CLEAR);
        assign clr_rise = Mem_Clear[i] & ~mem_clear_q[i];

        // Reads are only serviced outside a clear; an out-of-range read still
        // completes (returning zero) so the requester is not left waiting.
        assign do_read  = sel_rd & ~busy;

        // Any selected access during a clear, or any out-of-range selected
        // access, is an error.
        assign err_set  = (sel_rd | sel_wr) &
                          (busy | (sel_rd & ~rd_ok) | (sel_wr & ~wr_ok));

        // Clear FSM next-state logic. A rising edge while already clearing is
        // ignored because CLEAR never looks at clr_rise.
        always_comb begin
            // NOTE: defaults first so every path assigns every output and no
            // latch is inferred.
            state_d = state_q;
            ptr_d   = ptr_q;
            unique case (state_q)
                IDLE: begin
                    if (clr_rise) begin
                        state_d = CLEAR;
                        ptr_d   = '0;
                    end
                end
                CLEAR: begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge Bank_reset_n) begin
            if (!Bank_reset_n) begin
                state_q <= IDLE;
                ptr_q   <= '0;
                rdata_q <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                valid_q <= do_read;
                if (do_read) begin
                    rdata_q <= rd_ok ? mem[raddr] : '0;
                end
                // A new error in the same cycle as Err_Clear wins.
                err_q   <= err_set | (err_q & ~Err_Clear);
            end
        end

        // NOTE: the storage array has no reset; it is cleared only by the
        // clear sequence, so a reset mid-clear leaves it partially cleared.
        // Reading mem above with non-blocking updates here gives read-first
        // behaviour on a same-address read/write collision.
        always_ff @(posedge clk) begin
            if (busy) begin
                mem[ptr_q] <= '0;
            end else if (sel_wr && wr_ok) begin
                mem[waddr] <= wdata;
            end
        end

        assign Data_Out[i*Data_Width +: Data_Width] = rdata_q;
        assign Data_Valid[i] = valid_q;
        assign Clear_Busy[i] = busy;
        assign Access_Err[i] = err_q;

    end : g_bank

endmodule

// File: tb/tb_sram_bank_array.sv
// ---------------------------------------------------------------------------
// tb_sram_bank_array
//
// Directed testbench for sram_bank_array. One instance uses the default
// 16-word banks; a second instance uses 12-word banks so out-of-range
// addresses inside the 4-bit address space can be exercised.
// ---------------------------------------------------------------------------
module tb_sram_bank_array;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default-depth instance
    logic [NB-1:0]    mclr, cs, rd, wr;
    logic [NB*AW-1:0] ar, aw;
    logic [NB*DW-1:0] din;
    logic             ec;
    logic [NB*DW-1:0] dout;
    logic [NB-1:0]    dv, busy, err;

    // Depth-12 instance
    logic [NB-1:0]    s_mclr, s_cs, s_rd, s_wr;
    logic [NB*AW-1:0] s_ar, s_aw;
    logic [NB*DW-1:0] s_din;
    logic             s_ec;
    logic [NB*DW-1:0] s_dout;
    logic [NB-1:0]    s_dv, s_busy, s_err;

    int tests_run = 0;
    int fails     = 0;

    sram_bank_array dut (
        .clk            (clk),
        .Bank_reset_n   (rst_n),
        .Mem_Clear      (mclr),
        .En_Chip_Select (cs),
        .En_Read        (rd),
        .En_Write       (wr),
        .Addr_Read      (ar),
        .Addr_Write     (aw),
        .Data_In        (din),
        .Err_Clear      (ec),
        .Data_Out       (dout),
        .Data_Valid     (dv),
        .Clear_Busy     (busy),
        .Access_Err     (err)
    );

    sram_bank_array #(.Ram_Depth(12)) dut12 (
        .clk            (clk),
        .Bank_reset_n   (rst_n),
        .Mem_Clear      (s_mclr),
        .En_Chip_Select (s_cs),
        .En_Read        (s_rd),
        .En_Write       (s_wr),
        .Addr_Read      (s_ar),
        .Addr_Write     (s_aw),
        .Data_In        (s_din),
        .Err_Clear      (s_ec),
        .Data_Out       (s_dout),
        .Data_Valid     (s_dv),
        .Clear_Busy     (s_busy),
        .Access_Err     (s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mclr = '0; cs = '0; rd = '0; wr = '0;
        ar = '0; aw = '0; din = '0; ec = 1'b0;
    endtask

    task automatic s_idle();
        s_mclr = '0; s_cs = '0; s_rd = '0; s_wr = '0;
        s_ar = '0; s_aw = '0; s_din = '0; s_ec = 1'b0;
    endtask

    task automatic wr1(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        cs[b] = 1'b1;
        wr[b] = 1'b1;
        aw[b*AW +: AW] = a;
        din[b*DW +: DW] = d;
        tick();
        idle();
    endtask

    task automatic rd1(input int b, input logic [AW-1:0] a);
        idle();
        cs[b] = 1'b1;
        rd[b] = 1'b1;
        ar[b*AW +: AW] = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        s_idle();
        #12;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (dout !== '0) begin
            fails++; $display("FAIL reset_dout: got %h want 0", dout);
        end
        tests_run++;
        if ({dv, busy, err} !== '0) begin
            fails++; $display("FAIL reset_flags: got dv=%b busy=%b err=%b want all 0", dv, busy, err);
        end
        tests_run++;
        if ({s_dout, s_dv, s_busy, s_err} !== '0) begin
            fails++; $display("FAIL reset_dut12: got dout=%h dv=%b busy=%b err=%b want all 0",
                              s_dout, s_dv, s_busy, s_err);
        end
    endtask

    task automatic test_write_read();
        idle();
        cs = 3'b101; wr = 3'b101;
        aw[0 +: AW] = 4'd3; aw[2*AW +: AW] = 4'd3;
        din[0 +: DW] = 8'hA5; din[2*DW +: DW] = 8'h3C;
        tick();
        idle();
        cs = 3'b101; rd = 3'b101;
        ar[0 +: AW] = 4'd3; ar[2*AW +: AW] = 4'd3;
        tick();
        idle();
        tests_run++;
        if (dout[0 +: DW] !== 8'hA5 || dout[2*DW +: DW] !== 8'h3C) begin
            fails++; $display("FAIL wr_rd_data: got b0=%h b2=%h want a5/3c", dout[0 +: DW], dout[2*DW +: DW]);
        end
        tests_run++;
        if (dv !== 3'b101) begin
            fails++; $display("FAIL wr_rd_valid: got %b want 101", dv);
        end
        tick();
        tests_run++;
        if (dv !== 3'b000) begin
            fails++; $display("FAIL wr_rd_valid_drop: got %b want 000", dv);
        end
        tests_run++;
        if (dout[0 +: DW] !== 8'hA5 || dout[2*DW +: DW] !== 8'h3C) begin
            fails++; $display("FAIL wr_rd_hold: got b0=%h b2=%h want a5/3c", dout[0 +: DW], dout[2*DW +: DW]);
        end
    endtask

    task automatic test_collision();
        wr1(1, 4'd7, 8'h11);
        idle();
        cs[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b1;
        ar[AW +: AW] = 4'd7; aw[AW +: AW] = 4'd7; din[DW +: DW] = 8'h22;
        tick();
        idle();
        tests_run++;
        if (dout[DW +: DW] !== 8'h11 || dv !== 3'b010) begin
            fails++; $display("FAIL collision_old: got %h dv=%b want 11 dv=010", dout[DW +: DW], dv);
        end
        rd1(1, 4'd7);
        tests_run++;
        if (dout[DW +: DW] !== 8'h22) begin
            fails++; $display("FAIL collision_new: got %h want 22", dout[DW +: DW]);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 16; a++) wr1(2, 4'(a), 8'(8'hC0 + a));
        idle();
        mclr[2] = 1'b1;
        tick();
        mclr[2] = 1'b0;
        n = 0;
        while (busy[2] && n < 40) begin
            n++;
            cs[2] = 1'b1; rd[2] = 1'b1; ar[2*AW +: AW] = 4'd5;
            tick();
            tests_run++;
            if (dv[2] !== 1'b0) begin
                fails++; $display("FAIL clear_valid cycle %0d: got %b want 0", n, dv[2]);
            end
        end
        idle();
        tests_run++;
        if (n !== 16) begin
            fails++; $display("FAIL clear_busy_len: got %0d cycles want 16", n);
        end
        tests_run++;
        if (err !== 3'b100) begin
            fails++; $display("FAIL clear_err: got %b want 100", err);
        end
        for (int a = 0; a < 16; a++) begin
            rd1(2, 4'(a));
            tests_run++;
            if (dout[2*DW +: DW] !== 8'h00 || dv[2] !== 1'b1) begin
                fails++; $display("FAIL clear_data addr %0d: got %h dv=%b want 00 dv=1", a, dout[2*DW +: DW], dv[2]);
            end
        end
        rd1(0, 4'd3);
        tests_run++;
        if (dout[0 +: DW] !== 8'hA5) begin
            fails++; $display("FAIL clear_isolation_b0: got %h want a5", dout[0 +: DW]);
        end
        rd1(1, 4'd7);
        tests_run++;
        if (dout[DW +: DW] !== 8'h22) begin
            fails++; $display("FAIL clear_isolation_b1: got %h want 22", dout[DW +: DW]);
        end
        idle();
        ec = 1'b1;
        tick();
        idle();
        tests_run++;
        if (err !== 3'b000) begin
            fails++; $display("FAIL err_clear_main: got %b want 000", err);
        end
    endtask

    task automatic test_held_clear();
        int n;
        int rises;
        logic prev;
        n = 0; rises = 0; prev = 1'b0;
        idle();
        mclr[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (busy[0]) n++;
            if (busy[0] && !prev) rises++;
            prev = busy[0];
        end
        idle();
        tick();
        tests_run++;
        if (n !== 16 || rises !== 1) begin
            fails++; $display("FAIL held_clear: got %0d busy cycles in %0d runs want 16 in 1", n, rises);
        end
        tests_run++;
        if (busy !== 3'b000) begin
            fails++; $display("FAIL held_clear_idle: got %b want 000", busy);
        end
    endtask

    task automatic test_error();
        s_idle();
        s_cs[1] = 1'b1; s_wr[1] = 1'b1; s_aw[AW +: AW] = 4'd2; s_din[DW +: DW] = 8'h5A;
        tick();
        s_idle();
        s_cs[1] = 1'b1; s_rd[1] = 1'b1; s_ar[AW +: AW] = 4'd2;
        tick();
        s_idle();
        tests_run++;
        if (s_dout[DW +: DW] !== 8'h5A || s_err !== 3'b000) begin
            fails++; $display("FAIL err_inrange: got %h err=%b want 5a err=000", s_dout[DW +: DW], s_err);
        end
        s_cs[1] = 1'b1; s_rd[1] = 1'b1; s_ar[AW +: AW] = 4'd13;
        tick();
        s_idle();
        tests_run++;
        if (s_dout[DW +: DW] !== 8'h00 || s_dv !== 3'b010 || s_err !== 3'b010) begin
            fails++; $display("FAIL err_oob_read: got %h dv=%b err=%b want 00 dv=010 err=010",
                              s_dout[DW +: DW], s_dv, s_err);
        end
        tick();
        tests_run++;
        if (s_err !== 3'b010) begin
            fails++; $display("FAIL err_sticky: got %b want 010", s_err);
        end
        s_ec = 1'b1;
        tick();
        s_idle();
        tests_run++;
        if (s_err !== 3'b000) begin
            fails++; $display("FAIL err_clear: got %b want 000", s_err);
        end
        s_rd[1] = 1'b1; s_wr[1] = 1'b1; s_ar[AW +: AW] = 4'd13; s_aw[AW +: AW] = 4'd14;
        tick();
        s_idle();
        tests_run++;
        if (s_err !== 3'b000 || s_dv !== 3'b000) begin
            fails++; $display("FAIL err_no_cs: got err=%b dv=%b want 000/000", s_err, s_dv);
        end
        s_ec = 1'b1;
        s_cs[1] = 1'b1; s_wr[1] = 1'b1; s_aw[AW +: AW] = 4'd14; s_din[DW +: DW] = 8'hEE;
        tick();
        s_idle();
        tests_run++;
        if (s_err !== 3'b010) begin
            fails++; $display("FAIL err_clear_vs_set: got %b want 010", s_err);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [DW-1:0] exp;
        for (int a = 0; a < 16; a++) wr1(1, 4'(a), 8'(8'h40 + a));
        rd1(1, 4'd9);
        tests_run++;
        if (dout[DW +: DW] !== 8'h49) begin
            fails++; $display("FAIL rmc_pre: got %h want 49", dout[DW +: DW]);
        end
        idle();
        mclr[1] = 1'b1;
        tick();
        mclr[1] = 1'b0;
        cs[1] = 1'b1; rd[1] = 1'b1; ar[AW +: AW] = 4'd9;
        repeat (5) tick();
        idle();
        tests_run++;
        if (busy[1] !== 1'b1 || err[1] !== 1'b1) begin
            fails++; $display("FAIL rmc_busy: got busy=%b err=%b want 1/1", busy[1], err[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (dout !== '0 || dv !== '0 || busy !== '0 || err !== '0) begin
            fails++; $display("FAIL rmc_async: got dout=%h dv=%b busy=%b err=%b want all 0", dout, dv, busy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) begin
            rd1(1, 4'(a));
            exp = (a < 5) ? 8'h00 : 8'(8'h40 + a);
            tests_run++;
            if (dout[DW +: DW] !== exp) begin
                fails++; $display("FAIL rmc_data addr %0d: got %h want %h", a, dout[DW +: DW], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_clear();
        test_held_clear();
        test_error();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
- Responder end of the memory controller's per-SRAM control bus: holds all Nums_SRAM banks (input operand banks plus result banks) for the dot-product engine.
- Decodes the packed chip-select, read, write and address buses and returns registered read data one cycle after the request.
- Executes per-bank clear sequences and flags illegal accesses.
- Sits between the memory controller and the loader, compute pipeline and file-dump logic.

Parameters:
- Addr_Width, 4, address bits per bank.
- Ram_Depth, 1 << Addr_Width, words per bank; must be ≤ 2^Addr_Width.
- Nums_SRAM_In, 2, number of operand banks (indices 0..Nums_SRAM_In-1).
- Nums_SRAM_Out, 1, number of result banks (indices above the operand banks).
- Nums_SRAM, Nums_SRAM_In + Nums_SRAM_Out, total banks.
- Data_Width, 8, bits per word.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- Bank_reset_n  in  1  asynchronous active-low reset.
- Mem_Clear  in  Nums_SRAM  per-bank clear request; edge-detected.
- En_Chip_Select  in  Nums_SRAM  per-bank select; no access occurs without it.
- En_Read  in  Nums_SRAM  per-bank read enable.
- En_Write  in  Nums_SRAM  per-bank write enable.
- Addr_Read  in  Nums_SRAM*Addr_Width  packed read addresses; bank i uses slice [i*Addr_Width +: Addr_Width].
- Addr_Write  in  Nums_SRAM*Addr_Width  packed write addresses; same slicing.
- Data_In  in  Nums_SRAM*Data_Width  packed write data; bank i uses slice [i*Data_Width +: Data_Width].
- Err_Clear  in  1  synchronous clear of all Access_Err bits.
- Data_Out  out  Nums_SRAM*Data_Width  packed registered read data.
- Data_Valid  out  Nums_SRAM  high for exactly the cycle in which the bank's Data_Out holds a fresh read.
- Clear_Busy  out  Nums_SRAM  bank is executing a clear sequence.
- Access_Err  out  Nums_SRAM  sticky per-bank error flag.

Behaviour:
- Reset (Bank_reset_n low, asynchronous):
  - Data_Out=0, Data_Valid=0, Clear_Busy=0, Access_Err=0.
  - Every bank FSM goes to IDLE; clear pointers=0; Mem_Clear edge-detect history=0.
  - Memory contents are not reset.
- Per-bank FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR on a rising edge of Mem_Clear[i] (current 1, previous 0). Pointer=0, Clear_Busy[i]=1 from the next cycle.
  - In CLEAR, each cycle: write 0 to mem[pointer], then pointer+1.
  - CLEAR→IDLE after the cycle that writes address Ram_Depth-1, so a clear takes exactly Ram_Depth cycles.
  - Mem_Clear held high does not retrigger; a new rising edge during CLEAR is ignored.
- Write:
  - In IDLE, with En_Chip_Select[i]&En_Write[i] and write address < Ram_Depth, mem[Addr_Write slice] <= Data_In slice at the clock edge.
- Read (latency 1):
  - In IDLE, with En_Chip_Select[i]&En_Read[i], the next cycle has Data_Out slice = mem[Addr_Read slice] and Data_Valid[i]=1.
  - With no read, Data_Valid[i]=0 and Data_Out holds its last value.
- Read/write same bank, same cycle, same address: read-first; Data_Out returns the old word and the new word is stored.
- Read and write in the same cycle at different addresses are both performed (dual-port).
- Enables without En_Chip_Select: no access and no error.
- Access_Err[i] sets (sticky) when either of these occurs:
  - a selected read or write to an address ≥ Ram_Depth; a write is dropped, a read returns Data_Out=0 with Data_Valid=1;
  - any selected access while the bank is in CLEAR; the access is ignored and Data_Valid stays 0.
- Err_Clear clears all Access_Err bits; a new error in the same cycle wins (bit stays 1).
- Reset mid-clear aborts immediately; the bank is left partially cleared.
- Banks are fully independent; simultaneous clears, reads and writes on different banks do not interact.

Test Plan:
- Write then read:
  - Write bank 0 addr 3 = 8'hA5 and bank 2 addr 3 = 8'h3C in one cycle.
  - Read both the next cycle → one cycle later Data_Out slices = A5 / 3C, Data_Valid=3'b101.
  - Cycle after that → Data_Valid=0, data held.
- Read-first collision: bank 1 addr 7 holds 8'h11; write 8'h22 and read addr 7 in the same cycle → Data_Out=11; a re-read → 22.
- Clear:
  - Fill bank 2 with nonzero data, pulse Mem_Clear[2] for 1 cycle → Clear_Busy[2] high for exactly 16 cycles.
  - Reads during that window → Access_Err[2]=1, Data_Valid[2]=0.
  - Afterwards all 16 addresses read 0; banks 0/1 unchanged.
- Held clear: hold Mem_Clear[0] high 40 cycles → exactly one 16-cycle clear sequence.
- Error handling:
  - Ram_Depth=12, read addr 13 on bank 1 → Data_Out=0, Data_Valid=1, Access_Err[1]=1.
  - Err_Clear alone → 0.
  - Err_Clear together with a new bad write → stays 1.
- Async reset mid-clear: assert Bank_reset_n low at clear cycle 5 between clock edges → outputs 0 immediately; addrs 0–4 = 0 and addrs 5–15 retain prior data.
